rec_frame_ctrl: RTL and testbench

//  Parametrised receive controller: gates the bitstream shift register for one frame.

---
 rtl/rec_pkg.sv | 26 ++
 rtl/rec_cnt.sv | 43 ++++
 rtl/rec_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_rec_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rec_pkg.sv
// Shared types and constants for the receive frame controller.
//   rec_state_t : frame FSM states
//   PAR_*       : parity mode encodings for PARITY_MODE
//   SHIFT_*     : shift-register control codes driven on reg_shift
//   CNT_DW      : width of the shared delay/receive down-counter
package rec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RECV,
        PARITY,
        DONE
    } rec_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_RIGHT = 2'b01;

    // Must hold START_DELAY-1 (max 14) and PACKET_SIZE-1 (max 63).
    localparam int CNT_DW = 6;

endpackage

// File: rtl/rec_cnt.sv
// Loadable down-counter with a terminal flag.
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val on the next edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement on the next edge; saturates at zero, never wraps
//   term     : high while the count is zero
module rec_cnt
    import rec_pkg::*;
#(
    parameter int W = CNT_DW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == '0);

endmodule

// File: rtl/rec_frame_ctrl.sv
// Receive frame controller: gates the bitstream shift register for one frame.
// After rec_sig it waits START_DELAY cycles, shifts PACKET_SIZE data bits,
// optionally samples one parity bit, then pulses frame_done.
//   clk        : sclk, all logic on posedge
//   rst        : synchronous active-high reset
//   rec_sig    : frame start request (level, sampled each edge)
//   bit_in     : serial data bit, same bit the shift register samples
//   reg_shift  : 2'b00 hold, 2'b01 shift
//   reg_ld     : shift-register load enable, equals reg_shift[0]
//   busy       : high in every state except IDLE
//   frame_done : one-cycle pulse in DONE
//   parity_err : registered parity check result, valid from DONE until next start
//   bit_count  : data bits shifted so far in this frame
module rec_frame_ctrl
    import rec_pkg::*;
#(
    parameter int PACKET_SIZE = 8,
    parameter int START_DELAY = 3,
    parameter int PARITY_MODE = 0,
    parameter int CNT_W       = $clog2(PACKET_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_sig,
    input  logic             bit_in,
    output logic [1:0]       reg_shift,
    output logic             reg_ld,
    output logic             busy,
    output logic             frame_done,
    output logic             parity_err,
    output logic [CNT_W-1:0] bit_count
);

    if ((PACKET_SIZE < 1) || (PACKET_SIZE > 64)) begin : g_bad_size
        $error("rec_frame_ctrl: PACKET_SIZE must be in 1..64");
    end
    if ((START_DELAY < 0) || (START_DELAY > 15)) begin : g_bad_delay
        $error("rec_frame_ctrl: START_DELAY must be in 0..15");
    end
    if ((PARITY_MODE < PAR_NONE) || (PARITY_MODE > PAR_ODD)) begin : g_bad_parity
        $error("rec_frame_ctrl: PARITY_MODE must be 0, 1 or 2");
    end

    localparam logic HAS_PAR  = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
    localparam logic ODD_FLIP = (PARITY_MODE == PAR_ODD);
    localparam logic [CNT_DW-1:0] DLY_LOAD =
        (START_DELAY > 0) ? CNT_DW'(START_DELAY - 1) : '0;
    localparam logic [CNT_DW-1:0] PKT_LOAD = CNT_DW'(PACKET_SIZE - 1);

    rec_state_t       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic             perr_q, perr_d;

    logic              cnt_load;
    logic [CNT_DW-1:0] cnt_load_val;
    logic              cnt_dec;
    logic              cnt_term;

    // One counter serves both DELAY and RECV; it is reloaded on each entry.
    rec_cnt #(
        .W (CNT_DW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .term     (cnt_term)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        perr_d       = perr_q;
        cnt_load     = 1'b0;
        cnt_load_val = DLY_LOAD;
        cnt_dec      = 1'b0;

        case (state_q)
            // DONE accepts a new start exactly like IDLE (back-to-back frames).
            IDLE, DONE: begin
                if (rec_sig) begin
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                    perr_d    = 1'b0;
                    cnt_load  = 1'b1;
                    if (START_DELAY > 0) begin
                        state_d      = DELAY;
                        cnt_load_val = DLY_LOAD;
                    end else begin
                        state_d      = RECV;
                        cnt_load_val = PKT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (cnt_term) begin
                    state_d      = RECV;
                    cnt_load     = 1'b1;
                    cnt_load_val = PKT_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RECV: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                par_d     = par_q ^ bit_in;
                if (cnt_term) begin
                    state_d = HAS_PAR ? PARITY : DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            PARITY: begin
                perr_d  = par_q ^ bit_in ^ ODD_FLIP;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        reg_shift = SHIFT_HOLD;
        if (state_q == RECV) begin
            reg_shift = SHIFT_RIGHT;
        end
    end

    assign reg_ld     = reg_shift[0];
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign parity_err = HAS_PAR ? perr_q : 1'b0;
    assign bit_count  = bit_cnt_q;

endmodule

// File: tb/tb_rec_frame_ctrl.sv
// Directed bench for rec_frame_ctrl. Four instances share clk/rst/rec_sig/bit_in:
//   0: PACKET_SIZE=8  START_DELAY=3 PARITY_MODE=1
//   1: PACKET_SIZE=8  START_DELAY=0 PARITY_MODE=2
//   2: PACKET_SIZE=1  START_DELAY=3 PARITY_MODE=0
//   3: PACKET_SIZE=64 START_DELAY=3 PARITY_MODE=0
module tb_rec_frame_ctrl;

    logic clk;
    logic rst;
    logic rec_sig;
    logic bit_in;

    logic [1:0] rs0, rs1, rs2, rs3;
    logic       ld0, ld1, ld2, ld3;
    logic       bz0, bz1, bz2, bz3;
    logic       fd0, fd1, fd2, fd3;
    logic       pe0, pe1, pe2, pe3;
    logic [3:0] bc0;
    logic [3:0] bc1;
    logic [0:0] bc2;
    logic [6:0] bc3;

    logic [1:0] rs [4];
    logic       ld [4];
    logic       bz [4];
    logic       fd [4];
    logic       pe [4];
    logic [6:0] bc [4];

    assign rs[0] = rs0; assign rs[1] = rs1; assign rs[2] = rs2; assign rs[3] = rs3;
    assign ld[0] = ld0; assign ld[1] = ld1; assign ld[2] = ld2; assign ld[3] = ld3;
    assign bz[0] = bz0; assign bz[1] = bz1; assign bz[2] = bz2; assign bz[3] = bz3;
    assign fd[0] = fd0; assign fd[1] = fd1; assign fd[2] = fd2; assign fd[3] = fd3;
    assign pe[0] = pe0; assign pe[1] = pe1; assign pe[2] = pe2; assign pe[3] = pe3;
    assign bc[0] = {3'b000, bc0};
    assign bc[1] = {3'b000, bc1};
    assign bc[2] = {6'b000000, bc2};
    assign bc[3] = bc3;

    int errors = 0;
    int checks = 0;

    rec_frame_ctrl #(.PACKET_SIZE(8), .START_DELAY(3), .PARITY_MODE(1)) u_dut0 (
        .clk(clk), .rst(rst), .rec_sig(rec_sig), .bit_in(bit_in),
        .reg_shift(rs0), .reg_ld(ld0), .busy(bz0), .frame_done(fd0),
        .parity_err(pe0), .bit_count(bc0));

    rec_frame_ctrl #(.PACKET_SIZE(8), .START_DELAY(0), .PARITY_MODE(2)) u_dut1 (
        .clk(clk), .rst(rst), .rec_sig(rec_sig), .bit_in(bit_in),
        .reg_shift(rs1), .reg_ld(ld1), .busy(bz1), .frame_done(fd1),
        .parity_err(pe1), .bit_count(bc1));

    rec_frame_ctrl #(.PACKET_SIZE(1), .START_DELAY(3), .PARITY_MODE(0)) u_dut2 (
        .clk(clk), .rst(rst), .rec_sig(rec_sig), .bit_in(bit_in),
        .reg_shift(rs2), .reg_ld(ld2), .busy(bz2), .frame_done(fd2),
        .parity_err(pe2), .bit_count(bc2));

    rec_frame_ctrl #(.PACKET_SIZE(64), .START_DELAY(3), .PARITY_MODE(0)) u_dut3 (
        .clk(clk), .rst(rst), .rec_sig(rec_sig), .bit_in(bit_in),
        .reg_shift(rs3), .reg_ld(ld3), .busy(bz3), .frame_done(fd3),
        .parity_err(pe3), .bit_count(bc3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rec_sig = 1'b0; bit_in = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rec_sig = 1'b1; bit_in = 1'b1;
        step(); step();
        for (int d = 0; d < 4; d++) begin
            checks++; if (rs[d] !== 2'b00) begin errors++; $display("FAIL reset_shift dut%0d got=%b exp=00", d, rs[d]); end
            checks++; if (ld[d] !== 1'b0) begin errors++; $display("FAIL reset_ld dut%0d got=%b exp=0", d, ld[d]); end
            checks++; if (bz[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, bz[d]); end
            checks++; if (fd[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got=%b exp=0", d, fd[d]); end
            checks++; if (pe[d] !== 1'b0) begin errors++; $display("FAIL reset_perr dut%0d got=%b exp=0", d, pe[d]); end
            checks++; if (bc[d] !== 7'd0) begin errors++; $display("FAIL reset_count dut%0d got=%0d exp=0", d, bc[d]); end
        end
        rst = 1'b0; rec_sig = 1'b0; bit_in = 1'b0;
    endtask

    // Defaults with parity: DELAY k=0..2, RECV k=3..10, PARITY k=11, DONE k=12, IDLE k=13.
    task automatic test_timing();
        do_reset();
        rec_sig = 1'b1; step(); rec_sig = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            logic e_sh;
            int   e_bc;
            e_sh = (k >= 3) && (k <= 10);
            e_bc = (k < 3) ? 0 : ((k <= 10) ? (k - 3) : 8);
            checks++; if (rs[0] !== (e_sh ? 2'b01 : 2'b00)) begin errors++; $display("FAIL timing_shift k=%0d got=%b exp=%b", k, rs[0], {1'b0, e_sh}); end
            checks++; if (ld[0] !== e_sh) begin errors++; $display("FAIL timing_ld k=%0d got=%b exp=%b", k, ld[0], e_sh); end
            checks++; if (bz[0] !== (k <= 12)) begin errors++; $display("FAIL timing_busy k=%0d got=%b exp=%b", k, bz[0], (k <= 12)); end
            checks++; if (fd[0] !== (k == 12)) begin errors++; $display("FAIL timing_done k=%0d got=%b exp=%b", k, fd[0], (k == 12)); end
            checks++; if (bc[0] !== 7'(e_bc)) begin errors++; $display("FAIL timing_count k=%0d got=%0d exp=%0d", k, bc[0], e_bc); end
            if (k == 12) begin
                checks++; if (pe[0] !== 1'b0) begin errors++; $display("FAIL timing_perr got=%b exp=0", pe[0]); end
            end
            step();
        end
    endtask

    task automatic test_parity_even();
        logic [7:0] data;
        logic       pbits [2];
        data = 8'b1011_0001;
        pbits[0] = 1'b1;
        pbits[1] = 1'b0;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            rec_sig = 1'b1; step(); rec_sig = 1'b0;
            checks++; if (pe[0] !== 1'b0) begin errors++; $display("FAIL even_perr_cleared p=%0d got=%b exp=0", p, pe[0]); end
            for (int k = 0; k <= 12; k++) begin
                if (k == 12) begin
                    checks++; if (fd[0] !== 1'b1) begin errors++; $display("FAIL even_done p=%0d got=%b exp=1", p, fd[0]); end
                    checks++; if (pe[0] !== pbits[p]) begin errors++; $display("FAIL even_perr p=%0d got=%b exp=%b", p, pe[0], pbits[p]); end
                end
                if ((k >= 3) && (k <= 10)) bit_in = data[10 - k];
                else if (k == 11)          bit_in = pbits[p];
                else                       bit_in = 1'b0;
                step();
            end
            bit_in = 1'b1;
            step(); step(); step();
            checks++; if (pe[0] !== pbits[p]) begin errors++; $display("FAIL even_perr_hold p=%0d got=%b exp=%b", p, pe[0], pbits[p]); end
            bit_in = 1'b0;
        end
    endtask

    // No start delay: RECV k=0..7, PARITY k=8, DONE k=9.
    task automatic test_odd_nodelay();
        logic pbits [2];
        pbits[0] = 1'b1;
        pbits[1] = 1'b0;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            rec_sig = 1'b1;
            checks++; if (rs[1] !== 2'b00) begin errors++; $display("FAIL odd_pre_shift p=%0d got=%b exp=00", p, rs[1]); end
            step(); rec_sig = 1'b0;
            for (int k = 0; k <= 9; k++) begin
                checks++; if (rs[1] !== ((k <= 7) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL odd_shift p=%0d k=%0d got=%b", p, k, rs[1]); end
                if (k == 9) begin
                    checks++; if (fd[1] !== 1'b1) begin errors++; $display("FAIL odd_done p=%0d got=%b exp=1", p, fd[1]); end
                    checks++; if (pe[1] !== !pbits[p]) begin errors++; $display("FAIL odd_perr p=%0d got=%b exp=%b", p, pe[1], !pbits[p]); end
                    checks++; if (bc[1] !== 7'd8) begin errors++; $display("FAIL odd_count p=%0d got=%0d exp=8", p, bc[1]); end
                end
                bit_in = (k <= 7) ? 1'b1 : ((k == 8) ? pbits[p] : 1'b0);
                step();
            end
            bit_in = 1'b0;
        end
    endtask

    // rec_sig held high (with short drops mid-RECV) for three frames, then a
    // lone pulse during the fourth frame's RECV must not restart or extend it.
    task automatic test_back_to_back();
        do_reset();
        rec_sig = 1'b1; step();
        for (int k = 0; k <= 52; k++) begin
            int  m;
            logic e_fd, e_bz, e_sh;
            m    = k % 13;
            e_fd = (m == 12) && (k <= 51);
            e_bz = (k <= 51);
            e_sh = (m >= 3) && (m <= 10) && (k <= 51);
            checks++; if (fd[0] !== e_fd) begin errors++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, fd[0], e_fd); end
            checks++; if (bz[0] !== e_bz) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, bz[0], e_bz); end
            checks++; if (rs[0] !== (e_sh ? 2'b01 : 2'b00)) begin errors++; $display("FAIL b2b_shift k=%0d got=%b exp=%b", k, rs[0], {1'b0, e_sh}); end
            if (e_fd) begin
                checks++; if (bc[0] !== 7'd8) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=8", k, bc[0]); end
            end
            if (k < 40) rec_sig = !((m == 5) || (m == 6));
            else        rec_sig = (k == 45);
            step();
        end
        rec_sig = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nsh;
        do_reset();
        rec_sig = 1'b1; step(); rec_sig = 1'b0;
        repeat (6) step();
        checks++; if (rs[0] !== 2'b01) begin errors++; $display("FAIL mid_in_recv got=%b exp=01", rs[0]); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (rs[0] !== 2'b00) begin errors++; $display("FAIL mid_shift got=%b exp=00", rs[0]); end
        checks++; if (ld[0] !== 1'b0) begin errors++; $display("FAIL mid_ld got=%b exp=0", ld[0]); end
        checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bz[0]); end
        checks++; if (fd[0] !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", fd[0]); end
        checks++; if (bc[0] !== 7'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", bc[0]); end
        for (int k = 0; k < 12; k++) begin
            step();
            checks++; if (fd[0] !== 1'b0 || bz[0] !== 1'b0) begin errors++; $display("FAIL mid_idle k=%0d done=%b busy=%b exp=0,0", k, fd[0], bz[0]); end
        end
        nsh = 0;
        rec_sig = 1'b1; step(); rec_sig = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (rs[0] === 2'b01) nsh++;
            if (k == 12) begin
                checks++; if (fd[0] !== 1'b1) begin errors++; $display("FAIL mid_new_done got=%b exp=1", fd[0]); end
                checks++; if (bc[0] !== 7'd8) begin errors++; $display("FAIL mid_new_count got=%0d exp=8", bc[0]); end
            end
            step();
        end
        checks++; if (nsh != 8) begin errors++; $display("FAIL mid_new_shifts got=%0d exp=8", nsh); end
    endtask

    task automatic test_sizes();
        int n2, n3, nd2, nd3, dk2, dk3;
        logic [6:0] dbc2, dbc3;
        n2 = 0; n3 = 0; nd2 = 0; nd3 = 0; dk2 = -1; dk3 = -1;
        dbc2 = '0; dbc3 = '0;
        do_reset();
        rec_sig = 1'b1; step(); rec_sig = 1'b0;
        for (int k = 0; k < 80; k++) begin
            bit_in = k[0];
            if (rs[2] === 2'b01) n2++;
            if (rs[3] === 2'b01) n3++;
            if (fd[2] === 1'b1) begin nd2++; if (dk2 < 0) begin dk2 = k; dbc2 = bc[2]; end end
            if (fd[3] === 1'b1) begin nd3++; if (dk3 < 0) begin dk3 = k; dbc3 = bc[3]; end end
            step();
        end
        bit_in = 1'b0;
        checks++; if (n2 != 1)  begin errors++; $display("FAIL size1_shifts got=%0d exp=1", n2); end
        checks++; if (n3 != 64) begin errors++; $display("FAIL size64_shifts got=%0d exp=64", n3); end
        checks++; if (nd2 != 1 || dk2 != 4)  begin errors++; $display("FAIL size1_done count=%0d at=%0d exp=1 at 4", nd2, dk2); end
        checks++; if (nd3 != 1 || dk3 != 67) begin errors++; $display("FAIL size64_done count=%0d at=%0d exp=1 at 67", nd3, dk3); end
        checks++; if (dbc2 !== 7'd1)  begin errors++; $display("FAIL size1_count got=%0d exp=1", dbc2); end
        checks++; if (dbc3 !== 7'd64) begin errors++; $display("FAIL size64_count got=%0d exp=64", dbc3); end
        checks++; if (pe[2] !== 1'b0 || pe[3] !== 1'b0) begin errors++; $display("FAIL sizes_perr got=%b%b exp=00", pe[2], pe[3]); end
        checks++; if (bz[2] !== 1'b0 || bz[3] !== 1'b0) begin errors++; $display("FAIL sizes_idle got=%b%b exp=00", bz[2], bz[3]); end
    endtask

    initial begin
        rst = 1'b1; rec_sig = 1'b0; bit_in = 1'b0;
        test_reset();
        test_timing();
        test_parity_even();
        test_odd_nodelay();
        test_back_to_back();
        test_reset_mid();
        test_sizes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
